fetch_unit: RTL



---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Types and constants shared by the fetch stage and its instruction buffer.
package fetch_unit_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   localparam logic [31:0] INST_BYTES      = 32'd4;
   localparam int          FIFO_DEPTH_DFLT = 2;

   // Width needed to hold a count from 0 up to and including depth.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with push/pop/flush; flush wins over push and pop.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int  DEPTH   = FIFO_DEPTH_DFLT,
   parameter type entry_t = fetch_entry_t,
   parameter int  CNT_W   = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  entry_t           din_i,
   input  logic             pop_i,
   output entry_t           dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_END = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_q];
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (flush_i) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         if (push_i) wr_d = (wr_q == PTR_END) ? '0 : wr_q + PTR_ONE;
         if (pop_ok) rd_d = (rd_q == PTR_END) ? '0 : rd_q + PTR_ONE;
         case ({push_i, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: empty_o qualifies every read.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited imem requests, stale-response dropping on redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = FIFO_DEPTH_DFLT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int               CNT_W   = cnt_width(FIFO_DEPTH);
   localparam int               SUM_W   = CNT_W + 1;
   localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   logic             fifo_flush, fifo_push, fifo_pop;
   logic             fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   fetch_entry_t     fifo_din, fifo_head;

   logic [31:0]      redirect_tgt;
   logic [SUM_W-1:0] credit_used;
   logic             req_fire;

   assign redirect_tgt = redirect_pc & ~32'h3;
   assign credit_used  = SUM_W'(inflight_q) + SUM_W'(fifo_count);

   // Every outstanding request has a reserved buffer slot, so a kept response never finds the FIFO full.
   assign imem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_C);
   assign imem_addr      = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign fifo_din = '{pc: rsp_pc_q, inst: imem_rsp_data};
   assign fifo_pop = id_valid && id_ready;

   assign id_valid = !fifo_empty;
   assign id_inst  = fifo_empty ? '0 : fifo_head.inst;
   assign id_pc    = fifo_empty ? '0 : fifo_head.pc;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      fifo_flush = 1'b0;
      fifo_push  = 1'b0;
      if (redirect_valid) begin
         fetch_pc_d = redirect_tgt;
         rsp_pc_d   = redirect_tgt;
         fifo_flush = 1'b1;
         // A response arriving now belongs to the old stream and is consumed here.
         inflight_d = imem_rsp_valid ? inflight_q - ONE : inflight_q;
         drop_d     = inflight_d;
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + INST_BYTES;
         case ({req_fire, imem_rsp_valid})
            2'b10:   inflight_d = inflight_q + ONE;
            2'b01:   inflight_d = inflight_q - ONE;
            default: inflight_d = inflight_q;
         endcase
         if (imem_rsp_valid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - ONE;
            end else begin
               fifo_push = 1'b1;
               rsp_pc_d  = rsp_pc_q + INST_BYTES;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (fetch_entry_t),
      .CNT_W   (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (fifo_flush),
      .push_i  (fifo_push),
      .din_i   (fifo_din),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full));
   a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n) !(imem_rsp_valid && inflight_q == '0));
   a_drop_bounded: assert property (@(posedge clk) disable iff (!rst_n) drop_q <= inflight_q);

endmodule
